// File: rtl/byte_realigner.sv
`default_nettype none
// ============================================================================
// byte_realigner : strips a per-frame leading-byte offset from a word stream
//                  and emits a left-justified stream with sop/eop/byte count.
// Revision       : 1.0
// ============================================================================
module byte_realigner #(
    parameter int BITDATA = 32,
    parameter int SHW     = $clog2(BITDATA/8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITDATA-1:0] in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [SHW-1:0]     in_shift,
    output logic               out_valid,
    output logic [BITDATA-1:0] out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [SHW:0]       out_nbytes,
    output logic               protocol_err
);

    localparam int           B         = BITDATA/8;
    localparam logic [SHW:0] C_NB_FULL = (SHW+1)'(B);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [BITDATA-1:0] prev_q, prev_d;
    logic [SHW-1:0]     s_q, s_d;
    logic               first_q, first_d;

    logic               vld_q, vld_d;
    logic [BITDATA-1:0] data_q, data_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [SHW:0]       nb_q, nb_d;
    logic               err_q, err_d;

    logic               w_accept;
    logic               w_start;
    logic [SHW+2:0]     w_sh;
    logic [BITDATA-1:0] w_join;
    logic [BITDATA-1:0] w_tail;

    assign in_ready = ~rst & (state_q != ST_FLUSH);
    assign w_accept = in_valid & in_ready;

    // The held word supplies the leading bytes; the new word fills the top.
    assign w_sh   = {s_q, 3'b000};
    assign w_join = BITDATA'({in_data, prev_q} >> w_sh);
    assign w_tail = prev_q >> w_sh;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        s_d     = s_q;
        first_d = first_q;
        vld_d   = 1'b0;
        data_d  = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        nb_d    = '0;
        err_d   = 1'b0;
        w_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_sop) w_start = 1'b1;
                    else        err_d   = 1'b1;
                end
            end
            ST_HEAD, ST_BODY: begin
                if (w_accept) begin
                    if (in_sop) begin
                        // Old frame is abandoned silently; new one starts fresh.
                        err_d   = 1'b1;
                        w_start = 1'b1;
                    end else if (s_q == '0) begin
                        vld_d  = 1'b1;
                        data_d = in_data;
                        nb_d   = C_NB_FULL;
                        eop_d  = in_eop;
                        if (in_eop) state_d = ST_IDLE;
                    end else begin
                        vld_d   = 1'b1;
                        data_d  = w_join;
                        nb_d    = C_NB_FULL;
                        sop_d   = first_q;
                        first_d = 1'b0;
                        prev_d  = in_data;
                        state_d = in_eop ? ST_FLUSH : ST_BODY;
                    end
                end
            end
            ST_FLUSH: begin
                vld_d   = 1'b1;
                data_d  = w_tail;
                nb_d    = C_NB_FULL - {1'b0, s_q};
                eop_d   = 1'b1;
                sop_d   = first_q;
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_start) begin
            s_d = in_shift;
            if (in_shift == '0) begin
                vld_d   = 1'b1;
                data_d  = in_data;
                nb_d    = C_NB_FULL;
                sop_d   = 1'b1;
                eop_d   = in_eop;
                first_d = 1'b0;
                state_d = in_eop ? ST_IDLE : ST_BODY;
            end else begin
                prev_d  = in_data;
                first_d = 1'b1;
                state_d = in_eop ? ST_FLUSH : ST_HEAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            s_q     <= '0;
            first_q <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            nb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            s_q     <= s_d;
            first_q <= first_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            nb_q    <= nb_d;
            err_q   <= err_d;
        end
    end

    assign out_valid    = vld_q;
    assign out_data     = data_q;
    assign out_sop      = sop_q;
    assign out_eop      = eop_q;
    assign out_nbytes   = nb_q;
    assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_realigner.sv
`default_nettype none
// ============================================================================
// tb_byte_realigner : directed-vector bench for byte_realigner (B = 4).
// Revision          : 1.0
// ============================================================================
module tb_byte_realigner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [1:0]  in_shift;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_nbytes;
    logic        protocol_err;

    int vecs = 0;
    int errs = 0;

    byte_realigner #(.BITDATA(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_shift     (in_shift),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_nbytes   (out_nbytes),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    // {valid, sop, eop, nbytes, data, err}
    function automatic logic [38:0] pack(input logic v, input logic s, input logic e,
                                         input logic [2:0] n, input logic [31:0] d,
                                         input logic p);
        return {v, s, e, n, d, p};
    endfunction

    function automatic logic [38:0] obs();
        return {out_valid, out_sop, out_eop, out_nbytes, out_data, protocol_err};
    endfunction

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [1:0] sh, input logic [31:0] d);
        in_valid = v; in_sop = s; in_eop = e; in_shift = sh; in_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] exp;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        tick(); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL rst_outs: got %h want %h", obs(), exp); end
        rst = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        logic [38:0] exp;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h03020100); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h03020100, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL pt_w0: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL pt_ready: got %b want 1", in_ready); end
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h07060504); tick();
        exp = pack(1, 0, 1, 3'd4, 32'h07060504, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL pt_w1: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL pt_nostall: got %b want 1", in_ready); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL pt_idle: got %h want %h", obs(), exp); end
    endtask

    task automatic test_shift1();
        logic [38:0] exp;
        drive(1'b1, 1'b1, 1'b0, 2'd1, 32'h03020100); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL s1_head: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h07060504); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h04030201, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL s1_w0: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL s1_stall: got %b want 0", in_ready); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = pack(1, 0, 1, 3'd3, 32'h00070605, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL s1_flush: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL s1_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [38:0] exp;
        drive(1'b1, 1'b1, 1'b1, 2'd3, 32'hDDCCBBAA); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL single_accept: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL single_stall: got %b want 0", in_ready); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = pack(1, 1, 1, 3'd1, 32'h000000DD, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL single_out: got %h want %h", obs(), exp); end
    endtask

    task automatic test_back_to_back();
        logic [38:0] exp;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h13121110); tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'hFFFFFFFF); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_gap0: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b0, 2'd1, 32'h17161514); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h15141312, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_w0: got %h want %h", obs(), exp); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_gap1: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h1B1A1918); tick();
        exp = pack(1, 0, 0, 3'd4, 32'h19181716, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_w1: got %h want %h", obs(), exp); end
        // Next SOP presented during the flush cycle and held.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h23222120);
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_stall: got %b want 0", in_ready); end
        tick();
        exp = pack(1, 0, 1, 3'd2, 32'h00001B1A, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_flush: got %h want %h", obs(), exp); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        tick();
        exp = pack(1, 1, 0, 3'd4, 32'h23222120, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_next_sop: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h27262524); tick();
        exp = pack(1, 0, 1, 3'd4, 32'h27262524, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL b2b_next_eop: got %h want %h", obs(), exp); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
    endtask

    task automatic test_violations();
        logic [38:0] exp;
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF); tick();
        exp = pack(0, 0, 0, 3'd0, 32'h0, 1);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL viol_idle: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h33323130); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h33323130, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL viol_f0: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b1, 1'b0, 2'd1, 32'h43424140); tick();
        exp = pack(0, 0, 0, 3'd0, 32'h0, 1);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL viol_sop_body: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b1, 2'd3, 32'h47464544); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h44434241, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL viol_new_w0: got %h want %h", obs(), exp); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = pack(1, 0, 1, 3'd3, 32'h00474645, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL viol_new_flush: got %h want %h", obs(), exp); end
    endtask

    task automatic test_reset_head();
        logic [38:0] exp;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h53525150); tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rh_ready: got %b want 0", in_ready); end
        tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL rh_outs: got %h want %h", obs(), exp); end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h63626160); tick();
        exp = '0;
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL rh_head: got %h want %h", obs(), exp); end
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h67666564); tick();
        exp = pack(1, 1, 0, 3'd4, 32'h65646362, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL rh_w0: got %h want %h", obs(), exp); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0); tick();
        exp = pack(1, 0, 1, 3'd2, 32'h00006766, 0);
        vecs++; if (obs() !== exp) begin errs++; $display("FAIL rh_flush: got %h want %h", obs(), exp); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_shift1();
        test_single();
        test_back_to_back();
        test_violations();
        test_reset_head();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_realigner.md
# byte_realigner

Byte-granular stream realigner for the PCIe shifter path. It sits directly upstream of the `delay_module` pipeline. It strips a per-frame number of leading bytes (header offset) from a word stream by combining each incoming word with the previously held word. The result is a left-justified word stream with start, end and byte-count markers, which the downstream delay line retimes. The input has a one-cycle backpressure handshake that covers the end-of-frame flush.

## Interface
- `BITDATA`, 32: data word width. Must be a multiple of 8, with B = BITDATA/8 a power of two and B ≥ 2.
- `SHW`, $clog2(BITDATA/8): width of the shift field. Derived; do not override.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts a word; transfer occurs when `in_valid & in_ready`.
- `in_data`  in  BITDATA  input word; byte k = `in_data[8k+7:8k]`; byte 0 is first in the stream.
- `in_sop`  in  1  first word of a frame.
- `in_eop`  in  1  last word of a frame; may coincide with `in_sop`.
- `in_shift`  in  SHW  leading bytes to drop, 0..B-1; sampled only on an accepted SOP word.
- `out_valid`  out  1  output word valid; one-cycle qualifier, no backpressure.
- `out_data`  out  BITDATA  realigned word; bytes at or above `out_nbytes` are zero.
- `out_sop`  out  1  first output word of a frame.
- `out_eop`  out  1  last output word of a frame.
- `out_nbytes`  out  SHW+1  valid bytes in `out_data`, 1..B.
- `protocol_err`  out  1  one-cycle pulse on an input framing violation.

## Operation
- **State machine:** IDLE, HEAD, BODY, FLUSH. Registers held:
  - `prev` word
  - latched shift `s`
  - `first_out` flag
- **IDLE**
  - Accepted SOP with shift 0: pass-through word is output. Next state is BODY, or stays IDLE if `in_eop` is set.
  - Accepted SOP with shift > 0: store the word in `prev`, latch `s`, no output. Next state is HEAD, or FLUSH if `in_eop` is set.
  - Accepted word without SOP: dropped; `protocol_err` = 1.
- **HEAD / BODY, s > 0:** each accepted word `cur` emits bytes `prev[s..B-1]` followed by `cur[0..s-1]`, with `out_nbytes` = B. Then `prev` ← `cur`.
  - `out_sop` = `first_out`; `first_out` then clears.
  - On `in_eop`: go to FLUSH.
- **FLUSH:** `in_ready` = 0 for exactly one cycle. Emits `prev[s..B-1]` in the low bytes, zero-padded, with `out_nbytes` = B−s and `out_eop` = 1. `out_sop` = 1 if this is the frame's only output. Next state is IDLE.
- **BODY, s = 0:** pure pass-through, with `out_nbytes` = B and `out_eop` = `in_eop`. On EOP go to IDLE.
- **Word count:** an N-word frame always produces N output words.
- **SOP inside a frame (HEAD/BODY):**
  - The old frame is abandoned with no flush and no `out_eop`.
  - `protocol_err` = 1.
  - The new frame starts exactly as it would from IDLE.
- `in_valid` = 0 cycles inside a frame are allowed. Held state is kept and nothing is output.
- `in_shift` is ignored on non-SOP words.

## Timing
- **Reset:** `rst` = 1 forces the following at the next edge:
  - state IDLE
  - `out_valid`, `out_sop`, `out_eop`, `protocol_err` = 0
  - `out_data` = 0, `out_nbytes` = 0
  - `prev` = 0
- `in_ready` = 0 while `rst` is high. Otherwise `in_ready` = (state != FLUSH); it is decoded combinationally from the registered state.
- Reset mid-frame discards all held bytes. No partial frame or EOP is emitted.
- All outputs are registered:
  - Shift 0: word accepted at edge t appears at edge t.
  - Shift > 0: output j appears at the edge that accepts input word j+1. The final output appears at the edge ending the FLUSH cycle, one edge after EOP is accepted.
- The FLUSH cycle is the only stall. A following SOP presented during FLUSH must be held and is accepted on the next cycle.
- `protocol_err` is registered and asserts on the edge that detects the violation.

## Test plan
1. **Pass-through:** B=4, shift 0. Input 0x03020100 (sop), 0x07060504 (eop) → same two words, `out_nbytes` 4, sop/eop on words 0/1, no stall.
2. **Shift 1:** B=4, same words → 0x04030201 (sop, 4 bytes), then 0x00070605 (eop, 3 bytes). `in_ready` low for 1 cycle after EOP.
3. **Single-word frame:** sop+eop 0xDDCCBBAA, shift 3 → one output 0x000000DD, sop=eop=1, `out_nbytes` 1, emitted one edge later.
4. **Gaps and back-to-back frames:** 3-word frame, shift 2, with `in_valid` gaps, then an immediate next SOP held during FLUSH → 3 outputs, then the new frame is accepted one cycle later. No data loss and no `protocol_err`.
5. **Framing violations:** non-SOP word in IDLE → dropped, `protocol_err` pulse. SOP in BODY → new frame output correct, old frame has no `out_eop`, one `protocol_err` pulse.
6. **Reset in HEAD:** assert `rst` with shift 2 and one word held → all outputs 0 next edge. A fresh frame afterwards realigns with no leftover bytes.
